// File: rtl/mem_port_scheduler.sv
// Two-requester front end for a 2R/2W RAM: A on port 1, B on port 2, round-robin on write collisions.
// Optional read-during-write forwarding is enabled by defining MEM_SCHED_FWD_EN.
module mem_port_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              en_w1_n,
    output logic [ADDR_W-1:0] addr_w1,
    output logic [DATA_W-1:0] data_w1,
    output logic              en_r1_n,
    output logic [ADDR_W-1:0] addr_r1,
    input  logic [DATA_W-1:0] data_r1,

    output logic              en_w2_n,
    output logic [ADDR_W-1:0] addr_w2,
    output logic [DATA_W-1:0] data_w2,
    output logic              en_r2_n,
    output logic [ADDR_W-1:0] addr_r2,
    input  logic [DATA_W-1:0] data_r2,

    output logic [15:0]       conflict_cnt,
    output logic              idle
);

    logic              prio;    // 0: A wins the next collision, 1: B wins
    logic              collision;
    logic              a_wr_go, a_rd_go, b_wr_go, b_rd_go;
    logic [DATA_W-1:0] a_rd_data, b_rd_data;

    assign collision = a_req_valid & a_req_we & b_req_valid & b_req_we
                       & (a_req_addr == b_req_addr);

    assign a_req_ready = !reset & (!collision | !prio);
    assign b_req_ready = !reset & (!collision |  prio);

    assign a_wr_go = a_req_valid &  a_req_we & a_req_ready;
    assign a_rd_go = a_req_valid & !a_req_we & a_req_ready;
    assign b_wr_go = b_req_valid &  b_req_we & b_req_ready;
    assign b_rd_go = b_req_valid & !b_req_we & b_req_ready;

    assign en_w1_n = !a_wr_go;
    assign en_r1_n = !a_rd_go;
    assign addr_w1 = a_req_addr;
    assign addr_r1 = a_req_addr;
    assign data_w1 = a_req_wdata;

    assign en_w2_n = !b_wr_go;
    assign en_r2_n = !b_rd_go;
    assign addr_w2 = b_req_addr;
    assign addr_r2 = b_req_addr;
    assign data_w2 = b_req_wdata;

`ifdef MEM_SCHED_FWD_EN
    // A read racing the other port's write to the same word returns the new data.
    assign a_rd_data = (b_wr_go && (b_req_addr == a_req_addr)) ? b_req_wdata : data_r1;
    assign b_rd_data = (a_wr_go && (a_req_addr == b_req_addr)) ? a_req_wdata : data_r2;
`else
    assign a_rd_data = data_r1;
    assign b_rd_data = data_r2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio         <= 1'b0;
            conflict_cnt <= '0;
            a_rsp_valid  <= 1'b0;
            b_rsp_valid  <= 1'b0;
            a_rsp_rdata  <= '0;
            b_rsp_rdata  <= '0;
        end else begin
            a_rsp_valid <= a_rd_go;
            b_rsp_valid <= b_rd_go;
            if (a_rd_go) a_rsp_rdata <= a_rd_data;
            if (b_rd_go) b_rsp_rdata <= b_rd_data;
            if (collision) begin
                prio <= ~prio;
                if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    assign idle = !a_req_valid & !b_req_valid & !a_rsp_valid & !b_rsp_valid;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Bench for mem_port_scheduler: behavioural RAM, spec-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_scheduler;
    localparam int DW = 32;
    localparam int AW = 17;
    localparam int DEPTH = 1 << AW;
    localparam int STREAM_N = 4000;
    localparam int SAT_N = 65540;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [AW-1:0] a_req_addr = '0;
    logic [DW-1:0] a_req_wdata = '0;
    logic          b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [AW-1:0] b_req_addr = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_rdata, b_rsp_rdata;
    logic          en_w1_n, en_r1_n, en_w2_n, en_r2_n;
    logic [AW-1:0] addr_w1, addr_r1, addr_w2, addr_r2;
    logic [DW-1:0] data_w1, data_w2, data_r1, data_r2;
    logic [15:0]   conflict_cnt;
    logic          idle;

    mem_port_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .en_w1_n(en_w1_n), .addr_w1(addr_w1), .data_w1(data_w1),
        .en_r1_n(en_r1_n), .addr_r1(addr_r1), .data_r1(data_r1),
        .en_w2_n(en_w2_n), .addr_w2(addr_w2), .data_w2(data_w2),
        .en_r2_n(en_r2_n), .addr_r2(addr_r2), .data_r2(data_r2),
        .conflict_cnt(conflict_cnt), .idle(idle)
    );

    // RAM environment driven only by the DUT's port signals
    logic [DW-1:0] ram [0:DEPTH-1] = '{default: '0};
    assign data_r1 = en_r1_n ? '0 : ram[addr_r1];
    assign data_r2 = en_r2_n ? '0 : ram[addr_r2];
    always @(posedge clk) begin
        if (!en_w1_n) ram[addr_w1] <= data_w1;
        if (!en_w2_n) ram[addr_w2] <= data_w2;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory, priority owner, collision count, pending responses
    logic [DW-1:0] ref_mem [0:DEPTH-1] = '{default: '0};
    logic          m_prio_b = 1'b0;
    logic [15:0]   m_cnt = '0;
    logic          m_a_rv = 1'b0, m_b_rv = 1'b0;
    logic [DW-1:0] m_a_rd = '0, m_b_rd = '0;

    logic exp_clash, exp_a_rdy, exp_b_rdy, a_go, b_go;
    always_comb begin
        exp_clash = a_req_valid && b_req_valid && a_req_we && b_req_we && (a_req_addr == b_req_addr);
        exp_a_rdy = !reset && !(exp_clash && m_prio_b);
        exp_b_rdy = !reset && !(exp_clash && !m_prio_b);
        a_go      = a_req_valid && exp_a_rdy;
        b_go      = b_req_valid && exp_b_rdy;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prio_b <= 1'b0;
            m_cnt    <= '0;
            m_a_rv   <= 1'b0;
            m_b_rv   <= 1'b0;
            m_a_rd   <= '0;
            m_b_rd   <= '0;
        end else begin
            m_a_rv <= a_go && !a_req_we;
            m_b_rv <= b_go && !b_req_we;
            if (a_go && !a_req_we) begin
                m_a_rd <= ref_mem[a_req_addr];
`ifdef MEM_SCHED_FWD_EN
                if (b_go && b_req_we && b_req_addr == a_req_addr) m_a_rd <= b_req_wdata;
`endif
            end
            if (b_go && !b_req_we) begin
                m_b_rd <= ref_mem[b_req_addr];
`ifdef MEM_SCHED_FWD_EN
                if (a_go && a_req_we && a_req_addr == b_req_addr) m_b_rd <= a_req_wdata;
`endif
            end
            if (a_go && a_req_we) ref_mem[a_req_addr] <= a_req_wdata;
            if (b_go && b_req_we) ref_mem[b_req_addr] <= b_req_wdata;
            if (exp_clash) begin
                m_prio_b <= !m_prio_b;
                m_cnt    <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        check("a_ready", a_req_ready, exp_a_rdy);
        check("b_ready", b_req_ready, exp_b_rdy);
        check("en_port1", {en_w1_n, en_r1_n}, {!(a_go && a_req_we), !(a_go && !a_req_we)});
        check("en_port2", {en_w2_n, en_r2_n}, {!(b_go && b_req_we), !(b_go && !b_req_we)});
        check("addr_port1", {addr_w1, addr_r1}, {a_req_addr, a_req_addr});
        check("addr_port2", {addr_w2, addr_r2}, {b_req_addr, b_req_addr});
        check("wdata_port1", data_w1, a_req_wdata);
        check("wdata_port2", data_w2, b_req_wdata);
        check("a_rsp_valid", a_rsp_valid, m_a_rv);
        check("b_rsp_valid", b_rsp_valid, m_b_rv);
        if (m_a_rv || reset) check("a_rsp_rdata", a_rsp_rdata, m_a_rd);
        if (m_b_rv || reset) check("b_rsp_rdata", b_rsp_rdata, m_b_rd);
        check("conflict_cnt", conflict_cnt, m_cnt);
        check("idle", idle, !a_req_valid && !b_req_valid && !m_a_rv && !m_b_rv);
    end

    // Streaming monitor: run length of A responses
    logic stream_mon = 1'b0;
    int   s_cyc = 0, s_cnt = 0, s_first = -1, s_last = -1;
    always @(negedge clk) begin
        if (stream_mon) begin
            if (a_rsp_valid) begin
                if (s_first < 0) s_first = s_cyc;
                s_last = s_cyc;
                s_cnt++;
            end
            s_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = wd;
    endtask

    task automatic clear_all();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        step();

        // independent writes, then cross reads
        set_a(1, 1, 17'd5, 32'h00FF00FF);
        set_b(1, 1, 17'd319, 32'h12345678);
        step();
        set_a(1, 0, 17'd319, '0);
        set_b(1, 0, 17'd5, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_ind_a_valid", a_rsp_valid, 1'b1);
        check("lit_ind_a_rdata", a_rsp_rdata, 32'h12345678);
        check("lit_ind_b_rdata", b_rsp_rdata, 32'h00FF00FF);
        step();

        // first collision: A wins, B follows
        set_a(1, 1, 17'd7, 32'hAAAA);
        set_b(1, 1, 17'd7, 32'hBBBB);
        @(negedge clk);
        check("lit_col1_a_rdy", a_req_ready, 1'b1);
        check("lit_col1_b_rdy", b_req_ready, 1'b0);
        step();
        set_a(0, 0, '0, '0);
        @(negedge clk);
        check("lit_col1_b_rdy2", b_req_ready, 1'b1);
        step();
        clear_all();
        set_a(1, 0, 17'd7, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_col1_rdata", a_rsp_rdata, 32'hBBBB);
        check("lit_col1_cnt", conflict_cnt, 16'd1);
        step();

        // second collision: B now wins
        set_a(1, 1, 17'd7, 32'hAAAA);
        set_b(1, 1, 17'd7, 32'hBBBB);
        @(negedge clk);
        check("lit_col2_a_rdy", a_req_ready, 1'b0);
        check("lit_col2_b_rdy", b_req_ready, 1'b1);
        step();
        set_b(0, 0, '0, '0);
        @(negedge clk);
        check("lit_col2_cnt", conflict_cnt, 16'd2);
        step();
        clear_all();
        set_b(1, 0, 17'd7, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_col2_rdata", b_rsp_rdata, 32'hAAAA);
        step();

        // third collision leaves prio on B, then reset in the middof a fourth
        set_a(1, 1, 17'd7, 32'h3333);
        set_b(1, 1, 17'd7, 32'h4444);
        step();
        set_a(1, 1, 17'd7, 32'h5555);
        @(negedge clk);
        check("lit_col4_b_rdy", b_req_ready, 1'b1);
        check("lit_col4_a_rdy", a_req_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("lit_rst_en", {en_w1_n, en_r1_n, en_w2_n, en_r2_n}, 4'hF);
        check("lit_rst_ready", {a_req_ready, b_req_ready}, 2'b00);
        check("lit_rst_cnt", conflict_cnt, 16'd0);
        check("lit_rst_rsp", {a_rsp_valid, b_rsp_valid}, 2'b00);
        step();
        @(negedge clk);
        check("lit_rst_en2", {en_w1_n, en_r1_n, en_w2_n, en_r2_n}, 4'hF);
        step();
        clear_all();
        reset = 1'b0;
        step();

        // after reset A must win again; memory holds the pre-reset 0x3333
        set_a(1, 0, 17'd7, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_rst_noWrite", a_rsp_rdata, 32'h3333);
        step();
        set_a(1, 1, 17'd7, 32'h6666);
        set_b(1, 1, 17'd7, 32'h7777);
        @(negedge clk);
        check("lit_post_a_rdy", a_req_ready, 1'b1);
        check("lit_post_b_rdy", b_req_ready, 1'b0);
        step();
        set_a(0, 0, '0, '0);
        step();
        clear_all();
        set_a(1, 0, 17'd7, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_post_rdata", a_rsp_rdata, 32'h7777);
        check("lit_post_cnt", conflict_cnt, 16'd1);
        step();

        // read-during-write
        set_a(1, 1, 17'd9, 32'h1);
        step();
        clear_all();
        set_a(1, 0, 17'd9, '0);
        set_b(1, 1, 17'd9, 32'h2);
        step();
        clear_all();
        @(negedge clk);
`ifdef MEM_SCHED_FWD_EN
        check("lit_rdw_rdata", a_rsp_rdata, 32'h2);
`else
        check("lit_rdw_rdata", a_rsp_rdata, 32'h1);
`endif
        step();
        set_b(1, 0, 17'd9, '0);
        step();
        clear_all();
        @(negedge clk);
        check("lit_rdw_after", b_rsp_rdata, 32'h2);
        step();

        // streaming reads on A
        stream_mon = 1'b1;
        for (int i = 0; i < STREAM_N; i++) begin
            set_a(1, 0, AW'(i), '0);
            step();
        end
        clear_all();
        @(negedge clk);
        check("lit_stream_busy", idle, 1'b0);
        step();
        @(negedge clk);
        check("lit_stream_idle", idle, 1'b1);
        stream_mon = 1'b0;
        check("lit_stream_count", s_cnt, STREAM_N);
        check("lit_stream_span", s_last - s_first + 1, STREAM_N);

        // saturation under continuous same-address writes
        step();
        set_a(1, 1, 17'd11, 32'hA11A);
        set_b(1, 1, 17'd11, 32'hB11B);
        for (int i = 0; i < SAT_N; i++) step();
        clear_all();
        step();
        @(negedge clk);
        check("lit_sat_cnt", conflict_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
